// File: rtl/sound_scheduler.sv
// sound_scheduler: arbitrates game sound events and sequences the shared tone generator
//   clk, rst (async, active-low)
//   req_right/req_left/req_speed/req_win : one-cycle event pulses
//   sound_type : tone select (0 A, 1 D, 2 C), sound_en : audio gate
//   busy : not IDLE, ack[3:0] : one-cycle grant pulse {win, speed, left, right}
module sound_scheduler #(
    parameter int unsigned NOTE_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_right,
    input  logic       req_left,
    input  logic       req_speed,
    input  logic       req_win,
    output logic [1:0] sound_type,
    output logic       sound_en,
    output logic       busy,
    output logic [3:0] ack
);
    localparam logic [23:0] NOTE_LD = 24'(NOTE_CYCLES - 1);
    localparam logic [23:0] GAP_LD  = 24'(GAP_CYCLES - 1);
    localparam logic [1:0]  MELODY [4] = '{2'd2, 2'd0, 2'd1, 2'd2};

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t      state, state_n;
    logic [3:0]  pend, pend_n, req, grant;
    logic [23:0] cnt, cnt_n;
    logic [1:0]  idx, idx_n, nxt, type_n;
    logic        last, last_n, mel, mel_n;

    assign req = {req_win, req_speed, req_left, req_right};
    assign nxt = idx + 2'd1;

    always_comb begin
        grant   = '0;
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        mel_n   = mel;
        type_n  = sound_type;
        if (state == IDLE)
            grant = pend[3] ? 4'b1000 :
                    pend[2] ? 4'b0100 :
                    (pend[1] && pend[0]) ? (last ? 4'b0001 : 4'b0010) :
                    pend[1] ? 4'b0010 :
                    pend[0] ? 4'b0001 : 4'b0000;
        // last: 0 = right served most recently, 1 = left
        last_n = grant[0] ? 1'b0 : grant[1] ? 1'b1 : last;
        case (state)
            IDLE: if (|grant) begin
                state_n = PLAY;
                cnt_n   = NOTE_LD;
                mel_n   = grant[3];
                idx_n   = 2'd0;
                type_n  = grant[3] ? MELODY[0] : grant[2] ? 2'd2 : grant[1] ? 2'd1 : 2'd0;
            end
            PLAY: if (cnt == '0) begin
                state_n = GAP;
                cnt_n   = GAP_LD;
            end else cnt_n = cnt - 24'd1;
            GAP: if (cnt != '0) cnt_n = cnt - 24'd1;
            else if (mel && idx != 2'd3) begin
                state_n = PLAY;
                cnt_n   = NOTE_LD;
                idx_n   = nxt;
                type_n  = MELODY[nxt];
            end else begin
                state_n = IDLE;
                mel_n   = 1'b0;
                idx_n   = 2'd0;
            end
            default: state_n = IDLE;
        endcase
        // a win grant flushes the other requests; while the melody runs every pulse is dropped
        pend_n = (pend & ~grant & (grant[3] ? 4'b1000 : 4'b1111)) | ((mel || grant[3]) ? 4'b0000 : req);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pend       <= '0;
            cnt        <= '0;
            idx        <= '0;
            last       <= 1'b0;
            mel        <= 1'b0;
            sound_type <= 2'd0;
            sound_en   <= 1'b0;
            busy       <= 1'b0;
            ack        <= '0;
        end else begin
            state      <= state_n;
            pend       <= pend_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            last       <= last_n;
            mel        <= mel_n;
            sound_type <= type_n;
            sound_en   <= state_n == PLAY;
            busy       <= state_n != IDLE;
            ack        <= grant;
        end
    end
endmodule
